// File: rtl/uart_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_fifo_pkg
// Shared defaults for the UART receive/transmit FIFO and the bit positions of
// the per-entry side-band error field.
//   DEF_DATA_W / DEF_DEPTH / DEF_ERR_W : default geometry of uart_fifo_param
//   ERR_PE / ERR_FE / ERR_BI           : parity, framing and break bit indices
// ---------------------------------------------------------------------------
package uart_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ERR_W  = 3;

    localparam int ERR_PE = 0;
    localparam int ERR_FE = 1;
    localparam int ERR_BI = 2;

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read
// port (show-ahead head entry for the FIFO).
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from stored contents
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int WIDTH  = 11,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; occupancy is tracked by the pointers, so
    // stale contents are never observed and the array can map onto RAM cells.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_param.sv
// ---------------------------------------------------------------------------
// uart_fifo_param
// Parameterised UART FIFO with per-entry error side-band, show-ahead output,
// trigger threshold and pending-error indication (LSR bit 7 style).
//   clk, rst            : clock, asynchronous active-low reset
//   en, clr             : FIFO enable, synchronous flush
//   push_in, din, err_in: write request, data and error bits
//   pop_in              : read request
//   dout, err_out       : head entry (don't-care while empty)
//   empty, full, count  : occupancy
//   overrun, underrun   : one-cycle pulses for rejected push / pop on empty
//   threshold           : trigger level, thre_trigger when count reaches it
//   err_pending         : some stored entry carries nonzero error bits
// ---------------------------------------------------------------------------
module uart_fifo_param
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              push_in,
    input  logic              pop_in,
    input  logic [DATA_W-1:0] din,
    input  logic [ERR_W-1:0]  err_in,
    output logic [DATA_W-1:0] dout,
    output logic [ERR_W-1:0]  err_out,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overrun,
    output logic              underrun,
    input  logic [CNT_W-1:0]  threshold,
    output logic              thre_trigger,
    output logic              err_pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DATA_W + ERR_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ENT_W-1:0] head;
    logic             active;
    logic             push_acc;
    logic             pop_acc;
    logic             push_err;
    logic             pop_err;

    uart_fifo_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk    (clk),
        .we_i   (push_acc),
        .waddr_i(wr_ptr_q),
        .wdata_i({err_in, din}),
        .raddr_i(rd_ptr_q),
        .rdata_o(head)
    );

    assign {err_out, dout} = head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // Including rst keeps the pulse outputs quiet while reset is held.
    assign active   = en & ~clr & rst;
    assign pop_acc  = active & pop_in & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes data.
    assign push_acc = active & push_in & (~full | pop_acc);
    assign overrun  = active & push_in & full & ~pop_acc;
    assign underrun = active & pop_in & empty;

    assign push_err = push_acc & (err_in != '0);
    assign pop_err  = pop_acc & (err_out != '0);

    // threshold above DEPTH can never be reached because count <= DEPTH.
    assign thre_trigger = en & (threshold != '0) & (count_q >= threshold);
    assign err_pending  = (err_cnt_q != '0);

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            case ({push_err, pop_err})
                2'b10:   err_cnt_d = err_cnt_q + CNT_W'(1);
                2'b01:   err_cnt_d = err_cnt_q - CNT_W'(1);
                default: err_cnt_d = err_cnt_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_param
// Self-checking bench for uart_fifo_param (DATA_W=8, DEPTH=16, ERR_W=3).
// The driver applies one cycle of stimulus at each falling edge and pushes the
// expected observable state for that cycle, taken from a queue-based model of
// the FIFO, into a scoreboard. A separate monitor pops and compares a little
// after the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_uart_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ERR_W  = 3;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic              push_in = 1'b0;
    logic              pop_in = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [ERR_W-1:0]  err_in = '0;
    logic [DATA_W-1:0] dout;
    logic [ERR_W-1:0]  err_out;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overrun;
    logic              underrun;
    logic [CNT_W-1:0]  threshold = '0;
    logic              thre_trigger;
    logic              err_pending;

    uart_fifo_param #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ERR_W (ERR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr         (clr),
        .push_in     (push_in),
        .pop_in      (pop_in),
        .din         (din),
        .err_in      (err_in),
        .dout        (dout),
        .err_out     (err_out),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .underrun    (underrun),
        .threshold   (threshold),
        .thre_trigger(thre_trigger),
        .err_pending (err_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cnt;
        bit               emp;
        bit               ful;
        bit               ovr;
        bit               und;
        bit               thr;
        bit               errp;
        bit               head_v;
        logic [DATA_W-1:0] hd;
        logic [ERR_W-1:0]  he;
    } exp_t;

    exp_t                    exp_q[$];
    logic [ERR_W+DATA_W-1:0] model_q[$];   // {err, data}, front = oldest
    logic [CNT_W-1:0]        next_thr = '0;
    int                      n_tests = 0;
    int                      n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // One stimulus cycle: drive, record the expected view, then advance the model.
    task automatic do_cycle(input bit p, input bit q, input logic [DATA_W-1:0] d,
                            input logic [ERR_W-1:0] e, input bit en_v, input bit clr_v,
                            input bit rst_v);
        exp_t x;
        bit   act;
        bit   pop_ok;
        bit   push_ok;
        int   n;
        @(negedge clk);
        rst = rst_v; en = en_v; clr = clr_v;
        push_in = p; pop_in = q; din = d; err_in = e;
        threshold = next_thr;
        if (!rst_v) model_q.delete();
        n       = model_q.size();
        act     = en_v && !clr_v && rst_v;
        pop_ok  = act && q && (n > 0);
        push_ok = act && p && ((n < DEPTH) || pop_ok);
        x.cnt    = n;
        x.emp    = (n == 0);
        x.ful    = (n == DEPTH);
        x.ovr    = act && p && (n == DEPTH) && !pop_ok;
        x.und    = act && q && (n == 0);
        x.thr    = en_v && (next_thr != 0) && (n >= int'(next_thr));
        x.errp   = 1'b0;
        foreach (model_q[i]) if (model_q[i][ERR_W+DATA_W-1:DATA_W] != '0) x.errp = 1'b1;
        x.head_v = (n > 0);
        x.hd     = '0;
        x.he     = '0;
        if (n > 0) {x.he, x.hd} = model_q[0];
        exp_q.push_back(x);
        if (rst_v) begin
            if (clr_v) model_q.delete();
            else begin
                if (pop_ok)  void'(model_q.pop_front());
                if (push_ok) model_q.push_back({e, d});
            end
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [ERR_W-1:0] e);
        do_cycle(1'b1, 1'b0, d, e, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic pop();
        do_cycle(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    // Monitor: compares the DUT against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("count",        32'(count),        32'(e.cnt));
                check("empty",        32'(empty),        32'(e.emp));
                check("full",         32'(full),         32'(e.ful));
                check("overrun",      32'(overrun),      32'(e.ovr));
                check("underrun",     32'(underrun),     32'(e.und));
                check("thre_trigger", 32'(thre_trigger), 32'(e.thr));
                check("err_pending",  32'(err_pending),  32'(e.errp));
                if (e.head_v) begin
                    check("dout",    32'(dout),    32'(e.hd));
                    check("err_out", 32'(err_out), 32'(e.he));
                end
            end
        end
    end

    initial begin
        // Reset state, held for a cycle with the reset asserted.
        do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 8'h3C, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Fill to full, then one push too many.
        for (int i = 1; i <= 16; i++) push(8'(i), '0);
        idle();
        push(8'hAA, '0);
        idle();

        // Drain in order, then pop on empty.
        for (int i = 0; i < 16; i++) pop();
        pop();
        idle();

        // Threshold of 10.
        next_thr = 5'd10;
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i), '0);
        idle();
        push(8'h29, '0);
        idle();
        pop();
        idle();
        for (int i = 0; i < 9; i++) pop();
        next_thr = 5'd20;       // above DEPTH, never reached
        for (int i = 0; i < 16; i++) push(8'(i), '0);
        idle();
        for (int i = 0; i < 16; i++) pop();
        next_thr = '0;

        // Error side-band: one flagged entry among clean data.
        push(8'h11, '0);
        push(8'h55, 3'b010);
        push(8'h22, '0);
        idle();
        for (int i = 0; i < 3; i++) begin pop(); idle(); end

        // Full FIFO with simultaneous push+pop; 0x77 is the 20th push.
        do_reset();
        for (int i = 1; i <= 16; i++) push(8'(i), '0);
        do_cycle(1'b1, 1'b1, 8'h71, 3'b001, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h72, '0, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h73, 3'b100, 1'b1, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h77, '0, 1'b1, 1'b0, 1'b1);
        idle();
        for (int i = 0; i < 16; i++) pop();
        idle();

        // Flush, reset mid-burst and enable toggling.
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i), 3'(i));
        do_cycle(1'b1, 1'b0, 8'h99, '0, 1'b1, 1'b1, 1'b1);
        idle();
        push(8'h50, 3'b100);
        push(8'h51, '0);
        do_cycle(1'b1, 1'b0, 8'h52, '0, 1'b1, 1'b0, 1'b0);
        push(8'h60, '0);
        do_cycle(1'b1, 1'b0, 8'h61, '0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 8'h62, '0, 1'b0, 1'b0, 1'b1);
        push(8'h63, 3'b001);
        for (int i = 0; i < 14; i++) push(8'(8'h70 + i), '0);
        do_cycle(1'b1, 1'b0, 8'hEE, '0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 8'hEF, '0, 1'b0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b1);
        pop();
        idle();

        // Randomised traffic, alternating push-heavy and pop-heavy phases.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            bit               p;
            bit               q;
            bit               en_v;
            bit               clr_v;
            bit               rst_v;
            logic [ERR_W-1:0] e;
            int               bias;
            bias  = ((i / 100) % 2 == 0) ? 70 : 30;
            p     = ($urandom_range(0, 99) < bias);
            q     = ($urandom_range(0, 99) < (100 - bias));
            en_v  = ($urandom_range(0, 99) < 90);
            clr_v = ($urandom_range(0, 99) < 2);
            rst_v = ($urandom_range(0, 199) != 0);
            e     = ($urandom_range(0, 99) < 30) ? 3'($urandom_range(1, 7)) : '0;
            if ($urandom_range(0, 49) == 0) next_thr = 5'($urandom_range(0, 20));
            do_cycle(p, q, 8'($urandom), e, en_v, clr_v, rst_v);
        end
        idle();

        // Let the monitor consume every outstanding expectation.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
